uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver clocked by the 16 MHz board clock, LSB first.
- Converts an asynchronous serial input pin into bytes on a valid/ready byte interface.
- Counterpart to the board's UART transmitter. Provides the host-to-FPGA link on a spare TinyFPGA B pin.

Parameters:
- CLKS_PER_BIT, 139, clock cycles per bit (16 MHz / 115200 baud, rounded); legal range 4..65535.
- SYNC_STAGES, 2, number of input synchronizer flops; legal range 2..4.

Ports:
- pin3_clk_16mhz  input  1  system clock, rising edge.
- pin4_reset  input  1  synchronous active-high reset.
- rx_pin  input  1  asynchronous serial line; idles high.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts the byte on a clock edge where rx_valid&&rx_ready.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overrun  output  1  sticky; set when a byte is lost. Cleared only by reset.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of pin3_clk_16mhz. Resets FSM to IDLE, bit/baud counters to 0, and synchronizer flops to 1. Outputs after reset: rx_data=8'h00, rx_valid=0, busy=0, frame_err=0, overrun=0.
- Reset mid-frame: the partial byte is discarded with no error or valid. Reset while rx_valid=1 drops the held byte.
- Synchronizer: rx_pin passes through SYNC_STAGES flops. All decisions use the synchronized signal rx_s.
- Baud counter: width $clog2(CLKS_PER_BIT). It reloads to 0 on every state transition.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START.
  - START: when the count reaches (CLKS_PER_BIT-1)/2 (69 at default), rx_s is re-sampled. If 0 -> DATA with bit index 0. If 1 -> IDLE (glitch reject, no error).
  - DATA: every CLKS_PER_BIT cycles, rx_s is sampled into shift[bit_idx], LSB first. After bit 7 -> STOP (or PARITY when the feature is enabled).
  - STOP: after CLKS_PER_BIT cycles, rx_s is sampled.
    - Sampled 1: byte delivered (see handshake), -> IDLE.
    - Sampled 0: frame_err pulses 1 cycle, byte discarded, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. This prevents a held-low line from producing repeated frames.
- Sampling point: every bit is sampled mid-bit. A start edge is detected 0..1 cycle late plus the SYNC_STAGES delay.
- Delivery latency: rx_valid rises 1 cycle after the stop-bit sample. That is ≈9.5 bit-times + SYNC_STAGES + 1 cycles after the start edge on rx_pin.
- Handshake:
  - rx_data and rx_valid are registered.
  - rx_valid falls on the edge after rx_valid&&rx_ready, unless a new byte is delivered that same edge.
  - New byte delivered with the holding register empty or being accepted that cycle: load rx_data, rx_valid=1, no overrun.
  - New byte delivered with rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data is unchanged, and overrun is set to 1.
  - rx_data is stable whenever rx_valid=1 and no acceptance has occurred.
- A framing error never asserts rx_valid and never changes rx_data.
- A continuous low line produces one frame_err, then busy stays high in BREAK until the line returns high.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Even parity: the XOR of the 8 data bits plus the parity bit must be 0.
  - Added output port parity_err (1 bit): a one-cycle pulse at the parity sample on mismatch. The byte is discarded, and the FSM still proceeds through STOP.
  - A stop error on the same frame gives both pulses, in their respective cycles.
- Undefined: 8N1 only, and the parity_err port does not exist.

Test Plan:
- Reset with rx_pin=1 for 10 cycles -> all outputs 0, busy=0; after release, idle line for 2000 cycles -> no rx_valid.
- Send 0xA5 at 139 clk/bit, rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=8'hA5; frame_err=0; busy falls with delivery.
- Send 0x3C then 0x81 back-to-back with rx_ready=0 -> rx_data=8'h3C held, overrun=1 after the second stop bit. Raise rx_ready -> rx_valid drops, rx_data remains 8'h3C.
- Stop bit driven 0 on byte 0x55, then line high -> frame_err one-cycle pulse, rx_valid stays 0, FSM in BREAK until high. A following 0x12 is received correctly.
- 30-cycle low glitch on an idle line -> no busy beyond START, no valid, no error. Reset asserted mid-DATA of 0xFF -> busy=0 next cycle, no rx_valid.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> delivered. 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- UART receiver, LSB first, 8 data bits, 1 stop bit. It runs from
// the 16 MHz board clock and feeds the host-to-FPGA link.
//
// The asynchronous rx_pin goes through a SYNC_STAGES-deep synchronizer. The
// FSM samples every bit at mid-bit. Each received byte is presented on a
// registered valid/ready holding register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When this macro is defined, an even-parity bit is expected between the
//   data bits and the stop bit, and the parity_err port is added. When it is
//   not defined, the receiver is 8N1 only.
//
// Ports:
//   pin3_clk_16mhz  in   system clock, rising edge
//   pin4_reset      in   synchronous active-high reset
//   rx_pin          in   asynchronous serial line, idles high
//   rx_data         out  [7:0] received byte, valid while rx_valid=1
//   rx_valid        out  byte available, held until accepted
//   rx_ready        in   consumer accepts when rx_valid && rx_ready
//   busy            out  frame in progress (FSM not IDLE)
//   frame_err       out  one-cycle pulse on a bad stop bit
//   parity_err      out  one-cycle pulse on parity mismatch (parity build only)
//   overrun         out  sticky, set when a byte is dropped; cleared by reset
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       pin3_clk_16mhz,
    input  logic       pin4_reset,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: the XOR of the data bits and the parity bit must be zero.
    function automatic logic parity_bad(input logic [7:0] data, input logic par_bit);
        return ^{data, par_bit};
    endfunction
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_par_bad;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_busy;
    logic                   r_frame_err;
    logic                   r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                   r_parity_err;
`endif

    // Input synchronizer. It resets to the idle-high line level.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (pin4_reset) begin
            r_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_pin};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Receive FSM with the baud counter, shift register and output holding register.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (pin4_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_par_bad    <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // An acceptance clears valid. A delivery later in this block
            // overrides that.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end else begin
                r_rx_valid <= r_rx_valid;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                    r_par_bad <= 1'b0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_START: begin
                    if (r_cnt == HALF_CNT) begin
                        r_cnt <= '0;
                        // A line that is high again at mid-start is a glitch.
                        // It returns to IDLE silently.
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                        // On a mismatch the byte is discarded, but the stop bit is still checked.
                        if (parity_bad(r_shift, w_rx_s)) begin
                            r_parity_err <= 1'b1;
                            r_par_bad    <= 1'b1;
                        end else begin
                            r_par_bad    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (r_cnt == FULL_CNT) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (!r_par_bad) begin
                                // The new byte is loaded only if the holding
                                // register is empty or is being accepted this
                                // edge. Otherwise the new byte is dropped.
                                if (!r_rx_valid || rx_ready) begin
                                    r_rx_data  <= r_shift;
                                    r_rx_valid <= 1'b1;
                                end else begin
                                    r_overrun  <= 1'b1;
                                end
                            end else begin
                                r_overrun <= r_overrun;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                            r_busy      <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_BREAK: begin
                    // The FSM waits for the line to go high, so a held-low
                    // line does not produce repeated frames.
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_BREAK;
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 139;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Activity counters, sampled 1 time unit after each rising edge.
    int         mon_valid_cnt = 0;
    int         mon_ferr_cnt  = 0;
    int         mon_perr_cnt  = 0;
    int         mon_busy_cnt  = 0;
    logic [7:0] mon_last_data = 8'h00;
    logic       mon_busy_at_valid = 1'b1;
    logic       mon_prev_valid = 1'b0;

    int v0, f0, p0, b0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .pin3_clk_16mhz (clk),
        .pin4_reset     (rst),
        .rx_pin         (rx_pin),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .busy           (busy),
        .frame_err      (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err     (parity_err),
`endif
        .overrun        (overrun)
    );

    always @(posedge clk) begin
        #1;
        if (rx_valid) mon_valid_cnt <= mon_valid_cnt + 1;
        if (rx_valid && !mon_prev_valid) begin
            mon_last_data     <= rx_data;
            mon_busy_at_valid <= busy;
        end
        mon_prev_valid <= rx_valid;
        if (frame_err) mon_ferr_cnt <= mon_ferr_cnt + 1;
        if (busy) mon_busy_cnt <= mon_busy_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) mon_perr_cnt <= mon_perr_cnt + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_pin = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
        rx_pin = 1'b1;
    endtask

    task automatic snap();
        v0 = mon_valid_cnt;
        f0 = mon_ferr_cnt;
        p0 = mon_perr_cnt;
        b0 = mon_busy_cnt;
    endtask

    initial begin
        rst      = 1'b1;
        rx_pin   = 1'b1;
        rx_ready = 1'b1;

        // Reset values while reset is held.
        idle(10);
        chk("rst_data",    {24'd0, rx_data}, 32'h00);
        chk("rst_valid",   {31'd0, rx_valid}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_ferr",    {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;

        // An idle line produces nothing.
        snap();
        idle(2000);
        chk("idle_valid", mon_valid_cnt - v0, 32'd0);
        chk("idle_busy",  mon_busy_cnt - b0, 32'd0);

        // Byte 0xA5 with the consumer ready: valid for exactly one cycle.
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("a5_valid_cycles", mon_valid_cnt - v0, 32'd1);
        chk("a5_data",         {24'd0, mon_last_data}, 32'hA5);
        chk("a5_ferr",         mon_ferr_cnt - f0, 32'd0);
        chk("a5_busy_at_dlv",  {31'd0, mon_busy_at_valid}, 32'd0);
        chk("a5_overrun",      {31'd0, overrun}, 32'd0);

        // Two back-to-back bytes while the consumer is stalled: overrun.
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("ovr_first_valid",   {31'd0, rx_valid}, 32'd1);
        chk("ovr_first_overrun", {31'd0, overrun}, 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(5);
        chk("ovr_data_held", {24'd0, rx_data}, 32'h3C);
        chk("ovr_set",       {31'd0, overrun}, 32'd1);
        rx_ready = 1'b1;
        idle(1);
        chk("ovr_valid_drop", {31'd0, rx_valid}, 32'd0);
        chk("ovr_data_kept",  {24'd0, rx_data}, 32'h3C);
        chk("ovr_sticky",     {31'd0, overrun}, 32'd1);

        // A bad stop bit on 0x55, followed by a held-low line.
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        rx_pin = 1'b0;
        idle(300);
        chk("brk_ferr_once", mon_ferr_cnt - f0, 32'd1);
        chk("brk_no_valid",  mon_valid_cnt - v0, 32'd0);
        chk("brk_busy",      {31'd0, busy}, 32'd1);
        chk("brk_data",      {24'd0, rx_data}, 32'h3C);
        rx_pin = 1'b1;
        idle(10);
        chk("brk_exit", {31'd0, busy}, 32'd0);
        snap();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("post_brk_valid", mon_valid_cnt - v0, 32'd1);
        chk("post_brk_data",  {24'd0, mon_last_data}, 32'h12);

        // A 30-cycle glitch: START for HALF+1 = 70 cycles, then IDLE again.
        snap();
        rx_pin = 1'b0;
        idle(30);
        rx_pin = 1'b1;
        idle(200);
        chk("glitch_busy_cycles", mon_busy_cnt - b0, 32'd70);
        chk("glitch_valid",       mon_valid_cnt - v0, 32'd0);
        chk("glitch_ferr",        mon_ferr_cnt - f0, 32'd0);

        // Reset in the middle of the data bits of 0xFF.
        snap();
        send_bit(1'b0);
        rx_pin = 1'b1;
        idle(300);
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        idle(1);
        chk("mid_busy_rst",    {31'd0, busy}, 32'd0);
        chk("mid_overrun_rst", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        idle(1600);
        chk("mid_no_valid", mon_valid_cnt - v0, 32'd0);
        chk("mid_no_ferr",  mon_ferr_cnt - f0, 32'd0);

        // Reset while a byte is held drops that byte.
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("hold_valid", {31'd0, rx_valid}, 32'd1);
        chk("hold_data",  {24'd0, rx_data}, 32'h5A);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("hold_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("hold_rst_data",  {24'd0, rx_data}, 32'h00);
        rx_ready = 1'b1;
        idle(5);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even parity bit is 1.
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(20);
        chk("par_ok_valid", mon_valid_cnt - v0, 32'd1);
        chk("par_ok_data",  {24'd0, mon_last_data}, 32'h07);
        chk("par_ok_perr",  mon_perr_cnt - p0, 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        idle(20);
        chk("par_bad_perr",  mon_perr_cnt - p0, 32'd1);
        chk("par_bad_valid", mon_valid_cnt - v0, 32'd0);
        chk("par_bad_ferr",  mon_ferr_cnt - f0, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
